sha256_multiblock: RTL

- Parametrised SHA-256 engine for messages of up to MAX_WORDS 32-bit words; word count is selected per run.
- Generates FIPS 180-4 padding internally (word-granular message) and processes any number of 512-bit blocks.
- Optional double-hash mode, SHA256(SHA256(m)), for the Bitcoin hashing path.
- Reads the message from, and writes the 8-word digest to, the shared single-port word memory.

---
 rtl/sha256_pkg.sv | 72 +++++++
 rtl/sha256_multiblock_wsched.sv | 26 ++
 rtl/sha256_multiblock.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/sha256_pkg.sv
// Shared constants, state encodings and round/schedule helper functions
// for the multi-block SHA-256 engine.
package sha256_pkg;

  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_LOAD    = 3'd1;
  localparam state_t ST_COMPUTE = 3'd2;
  localparam state_t ST_UPDATE  = 3'd3;
  localparam state_t ST_WRITE   = 3'd4;

  // Index 0 holds a (or h0), index 7 holds h (or h7).
  typedef logic [7:0][31:0] hstate_t;

  localparam logic [31:0] K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [31:0] H_INIT [0:7] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  function automatic hstate_t init_state();
    hstate_t r;
    for (int i = 0; i < 8; i++) r[i] = H_INIT[i];
    return r;
  endfunction

  function automatic logic [31:0] rightrotate(input logic [31:0] x, input int unsigned r);
    return (x >> r) | (x << (32 - r));
  endfunction

  function automatic logic [31:0] sigma0(input logic [31:0] x);
    return rightrotate(x, 7) ^ rightrotate(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sigma1(input logic [31:0] x);
    return rightrotate(x, 17) ^ rightrotate(x, 19) ^ (x >> 10);
  endfunction

  function automatic logic [31:0] Sigma0(input logic [31:0] x);
    return rightrotate(x, 2) ^ rightrotate(x, 13) ^ rightrotate(x, 22);
  endfunction

  function automatic logic [31:0] Sigma1(input logic [31:0] x);
    return rightrotate(x, 6) ^ rightrotate(x, 11) ^ rightrotate(x, 25);
  endfunction

  function automatic hstate_t sha256_op(input hstate_t s, input logic [31:0] w, input logic [31:0] k);
    logic [31:0] t1, t2;
    hstate_t r;
    t1 = s[7] + Sigma1(s[4]) + ((s[4] & s[5]) ^ (~s[4] & s[6])) + k + w;
    t2 = Sigma0(s[0]) + ((s[0] & s[1]) ^ (s[0] & s[2]) ^ (s[1] & s[2]));
    r = {s[6:0], t1 + t2};
    r[4] = s[3] + t1;
    return r;
  endfunction

  // Message words plus the 0x80000000 marker and the 2-word length field.
  function automatic logic [31:0] num_blocks(input logic [31:0] n);
    return (n + 32'd18) >> 4;
  endfunction

endpackage

// File: rtl/sha256_multiblock_wsched.sv
// Rolling 16-word message-schedule window; W_t is always the oldest word.
module sha256_multiblock_wsched
  import sha256_pkg::*;
(
  input  logic        clk,
  input  logic        load,
  input  logic        advance,
  input  logic [31:0] load_word,
  output logic [31:0] w_t
);

  logic [31:0] win [0:15];
  logic [31:0] w_next;

  // W[t+16] computed from the window that currently starts at W[t].
  assign w_next = sigma1(win[14]) + win[9] + sigma0(win[1]) + win[0];
  assign w_t    = win[0];

  always_ff @(posedge clk) begin
    if (load || advance) begin
      for (int i = 0; i < 15; i++) win[i] <= win[i + 1];
      win[15] <= load ? load_word : w_next;
    end
  end

endmodule

// File: rtl/sha256_multiblock.sv
// Multi-block SHA-256 with internal word-granular padding and optional
// double hashing; message read from and digest written to a shared word memory.
module sha256_multiblock
  import sha256_pkg::*;
#(
  parameter int MAX_WORDS = 64,
  parameter int NW_W      = $clog2(MAX_WORDS + 1)
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic [NW_W-1:0] num_words,
  input  logic            double_hash,
  input  logic [15:0]     message_addr,
  input  logic [15:0]     output_addr,
  output logic            done,
  output logic            err,
  output logic            mem_clk,
  output logic            mem_we,
  output logic [15:0]     mem_addr,
  output logic [31:0]     mem_write_data,
  input  logic [31:0]     mem_read_data
);

  state_t      state;
  logic [6:0]  cnt;
  logic [15:0] msg_base, out_base;
  logic [31:0] n_words_q, nblk, blk, j_cap, j_rd, j_nb, load_word, w_t;
  logic [3:0]  k_cap;
  logic        dh_q, pass, accept, ws_load, ws_advance;
  hstate_t     h, s;

  assign mem_clk    = clk;
  assign done       = (state == ST_IDLE);
  assign accept     = (state == ST_IDLE) && start && (32'(num_words) <= 32'(MAX_WORDS));
  assign nblk       = num_blocks(n_words_q);
  assign k_cap      = 4'(cnt - 7'd1);
  assign j_cap      = {blk[27:0], 4'b0} + 32'(k_cap);
  assign j_rd       = {blk[27:0], 4'b0} + 32'(cnt) + 32'd1;
  assign j_nb       = {blk[27:0] + 28'd1, 4'b0};
  assign ws_load    = (state == ST_LOAD) && (cnt != 7'd0);
  assign ws_advance = (state == ST_COMPUTE);

  // Word captured in LOAD cycle cnt is padded-message word cnt-1 of this block.
  always_comb begin
    load_word = 32'h0;
    if (pass) begin
      if (k_cap < 4'd8)        load_word = h[k_cap[2:0]];
      else if (k_cap == 4'd8)  load_word = 32'h8000_0000;
      else if (k_cap == 4'd15) load_word = 32'd256;
    end else if (j_cap < n_words_q) begin
      load_word = mem_read_data;
    end else if (j_cap == n_words_q) begin
      load_word = 32'h8000_0000;
    end else if (j_cap == {nblk[27:0], 4'b0} - 32'd1) begin
      load_word = {n_words_q[26:0], 5'b0};
    end
  end

  sha256_multiblock_wsched u_wsched (
    .clk       (clk),
    .load      (ws_load),
    .advance   (ws_advance),
    .load_word (load_word),
    .w_t       (w_t)
  );

  // Memory port is registered, so each address is issued one cycle ahead.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= ST_IDLE;
      cnt            <= 7'd0;
      err            <= 1'b0;
      mem_we         <= 1'b0;
      mem_addr       <= 16'h0;
      mem_write_data <= 32'h0;
      msg_base       <= 16'h0;
      out_base       <= 16'h0;
      n_words_q      <= 32'h0;
      dh_q           <= 1'b0;
      pass           <= 1'b0;
      blk            <= 32'h0;
    end else begin
      err            <= 1'b0;
      mem_we         <= 1'b0;
      mem_addr       <= 16'h0;
      mem_write_data <= 32'h0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            msg_base  <= message_addr;
            out_base  <= output_addr;
            n_words_q <= 32'(num_words);
            dh_q      <= double_hash;
            pass      <= 1'b0;
            blk       <= 32'h0;
            cnt       <= 7'd0;
            state     <= ST_LOAD;
            if (num_words != '0) mem_addr <= message_addr;
          end else if (start) begin
            err <= 1'b1;
          end
        end
        ST_LOAD: begin
          if (cnt < 7'd15 && !pass && j_rd < n_words_q) mem_addr <= msg_base + j_rd[15:0];
          if (cnt == 7'd16) begin
            cnt   <= 7'd0;
            state <= ST_COMPUTE;
          end else begin
            cnt <= cnt + 7'd1;
          end
        end
        ST_COMPUTE: begin
          if (cnt == 7'd63) begin
            cnt   <= 7'd0;
            state <= ST_UPDATE;
          end else begin
            cnt <= cnt + 7'd1;
          end
        end
        ST_UPDATE: begin
          if (!pass && (blk + 32'd1 < nblk)) begin
            blk   <= blk + 32'd1;
            state <= ST_LOAD;
            if (j_nb < n_words_q) mem_addr <= msg_base + j_nb[15:0];
          end else if (!pass && dh_q) begin
            pass  <= 1'b1;
            blk   <= 32'h0;
            state <= ST_LOAD;
          end else begin
            state <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          if (cnt < 7'd8) begin
            mem_we         <= 1'b1;
            mem_addr       <= out_base + 16'(cnt);
            mem_write_data <= h[cnt[2:0]];
          end
          if (cnt == 7'd8) begin
            cnt   <= 7'd0;
            state <= ST_IDLE;
          end else begin
            cnt <= cnt + 7'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (accept) h <= init_state();
    case (state)
      ST_LOAD: begin
        if (cnt == 7'd16) begin
          if (pass) begin
            s <= init_state();
            h <= init_state();
          end else begin
            s <= h;
          end
        end
      end
      ST_COMPUTE: s <= sha256_op(s, w_t, K[cnt[5:0]]);
      ST_UPDATE: for (int i = 0; i < 8; i++) h[i] <= h[i] + s[i];
      default: ;
    endcase
  end

endmodule
